// File: rtl/mm_operand_fetch.sv
// Operand-fetch stage for the memory-memory datapath: reads A then B (or takes an
// immediate B) over a single-port read handshake and holds them stable for the ALU.
module mm_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm_b,
  input  logic [2:0]        funct3_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        funct3,
  output logic              op_valid,
  input  logic              op_ack
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    WAIT_A,
    REQ_B,
    WAIT_B,
    HOLD
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_a_q;
  logic [ADDR_W-1:0]   addr_b_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_b_q;

  // Every output is a register updated alongside the state, so nothing the ALU
  // sees can glitch or follow an input combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      A         <= '0;
      B         <= '0;
      funct3    <= '0;
      op_valid  <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      use_imm_q <= 1'b0;
      imm_b_q   <= '0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_a_q  <= addr_a;
            addr_b_q  <= addr_b;
            use_imm_q <= use_imm;
            imm_b_q   <= imm_b;
            funct3    <= funct3_in;
            mem_rd    <= 1'b1;
            mem_addr  <= addr_a;
            ready     <= 1'b0;
            state     <= REQ_A;
          end
        end
        REQ_A: state <= WAIT_A;
        WAIT_A: begin
          if (mem_rvalid) begin
            A <= mem_rdata;
            if (use_imm_q) begin
              B        <= imm_b_q;
              op_valid <= 1'b1;
              state    <= HOLD;
            end else if (addr_b_q == addr_a_q) begin
              // Same word as A: reuse the returned data instead of reading again.
              B        <= mem_rdata;
              op_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= addr_b_q;
              state    <= REQ_B;
            end
          end
        end
        REQ_B: state <= WAIT_B;
        WAIT_B: begin
          if (mem_rvalid) begin
            B        <= mem_rdata;
            op_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (op_ack) begin
            op_valid <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          op_valid <= 1'b0;
          ready    <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_operand_fetch.sv
// Scoreboard bench for mm_operand_fetch with a latency-programmable memory model.
module tb_mm_operand_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic [15:0] addr_a;
  logic [15:0] addr_b;
  logic        use_imm;
  logic [15:0] imm_b;
  logic [2:0]  funct3_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  funct3;
  logic        op_valid;
  logic        op_ack;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rd_q[$];
  int          rd_cyc[$];
  logic [15:0] mem [0:255];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_count = 0;
  int          lat = 1;
  int          acc_cyc = 0;
  bit          spur = 0;
  bit          track = 1;

  mm_operand_fetch #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .addr_a(addr_a), .addr_b(addr_b), .use_imm(use_imm), .imm_b(imm_b),
    .funct3_in(funct3_in), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .A(A), .B(B),
    .funct3(funct3), .op_valid(op_valid), .op_ack(op_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: answers each read strobe after 'lat' cycles; 'spur' injects a stray rvalid.
  initial begin
    int          cnt;
    bit          spur_now;
    logic [15:0] pend;
    cnt = 0;
    pend = '0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      spur_now = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem[pend[7:0]];
        end
      end else if (spur) begin
        mem_rvalid = 1'b1;
        mem_rdata = 16'hBEEF;
        spur = 1'b0;
        spur_now = 1'b1;
      end
      @(negedge clk);
      if (mem_rvalid && !spur_now && track)
        checkOutput("mem_addr_hold", {16'h0, mem_addr}, {16'h0, pend});
      if (mem_rd) begin
        rd_count++;
        rd_cyc.push_back(cyc);
        if (rd_q.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
        else checkOutput("mem_addr", {16'h0, mem_addr}, {16'h0, rd_q.pop_front()});
        pend = mem_addr;
        cnt = lat;
      end
    end
  end

  // Result monitor: pops one expectation per op_valid window and checks it every HOLD cycle.
  initial begin
    bit   prev;
    bit   have;
    exp_t cur;
    prev = 1'b0;
    have = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (op_valid) begin
        if (!prev) begin
          if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
            have = 1'b0;
          end else begin
            cur = sb.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          checkOutput("A", {16'h0, A}, {16'h0, cur.a});
          checkOutput("B", {16'h0, B}, {16'h0, cur.b});
          checkOutput("funct3", {29'h0, funct3}, {29'h0, cur.f});
        end
        checkOutput("ready_in_hold", {31'h0, ready}, 32'd0);
        checkOutput("mem_rd_in_hold", {31'h0, mem_rd}, 32'd0);
      end
      prev = op_valid;
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic ui,
                               input logic [15:0] imm, input logic [2:0] f);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_start", {31'h0, ready}, 32'd1);
    start = 1'b1;
    addr_a = a;
    addr_b = b;
    use_imm = ui;
    imm_b = imm;
    funct3_in = f;
    e.a = mem[a[7:0]];
    e.b = ui ? imm : mem[b[7:0]];
    e.f = f;
    sb.push_back(e);
    rd_q.push_back(a);
    if (!ui && b != a) rd_q.push_back(b);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    addr_a = 16'($urandom);
    addr_b = 16'($urandom);
    use_imm = 1'($urandom);
    imm_b = 16'($urandom);
    funct3_in = 3'($urandom);
  endtask

  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!op_valid && n < 100);
    if (!op_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic ackOp(input logic with_start);
    @(negedge clk);
    op_ack = 1'b1;
    start = with_start;
    addr_a = 16'h0010;
    addr_b = 16'h0020;
    @(posedge clk);
    #1;
    op_ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_ack", {31'h0, ready}, 32'd1);
    checkOutput("valid_after_ack", {31'h0, op_valid}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, {31'h0, ready}, 32'd1);
    checkOutput({tag, "_mem_rd"}, {31'h0, mem_rd}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'd0);
    checkOutput({tag, "_A"}, {16'h0, A}, 32'd0);
    checkOutput({tag, "_B"}, {16'h0, B}, 32'd0);
    checkOutput({tag, "_funct3"}, {29'h0, funct3}, 32'd0);
    checkOutput({tag, "_op_valid"}, {31'h0, op_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'h1234;
    mem[8'h20] = 16'h0034;
    mem[8'h30] = 16'h8000;
    mem[8'h42] = 16'h0005;
    mem[8'h50] = 16'h00AA;
    mem[8'h60] = 16'hDEAD;
    reset = 1'b1;
    start = 1'b0;
    addr_a = '0;
    addr_b = '0;
    use_imm = 1'b0;
    imm_b = '0;
    funct3_in = '0;
    op_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    // Two-read fetch with 1-cycle memory
    lat = 1;
    base = rd_count;
    applyStimulus(16'h0010, 16'h0020, 1'b0, 16'h0, 3'd1);
    waitValid(n);
    checkOutput("lat_two_read", n, 32'd5);
    checkOutput("reads_two_read", rd_count - base, 32'd2);
    if (rd_count - base >= 2) begin
      checkOutput("rd1_cycle", rd_cyc[base] - acc_cyc + 1, 32'd1);
      checkOutput("rd2_cycle", rd_cyc[base + 1] - acc_cyc + 1, 32'd3);
    end
    ackOp(1'b0);
    checkOutput("A_kept_idle", {16'h0, A}, 32'h1234);
    checkOutput("B_kept_idle", {16'h0, B}, 32'h0034);

    // Immediate B with 4-cycle memory
    lat = 4;
    base = rd_count;
    applyStimulus(16'h0030, 16'h0099, 1'b1, 16'hFFFF, 3'd7);
    waitValid(n);
    checkOutput("lat_imm", n, 32'd6);
    checkOutput("reads_imm", rd_count - base, 32'd1);
    ackOp(1'b0);

    // Same-address operands
    lat = 1;
    base = rd_count;
    applyStimulus(16'h0042, 16'h0042, 1'b0, 16'h1111, 3'd3);
    waitValid(n);
    checkOutput("lat_same", n, 32'd3);
    checkOutput("reads_same", rd_count - base, 32'd1);
    ackOp(1'b0);

    // Long hold with stray rvalid pulses, then ack together with start
    lat = 2;
    applyStimulus(16'h0050, 16'h0020, 1'b0, 16'h0, 3'd5);
    waitValid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2 || i == 6) spur = 1'b1;
    end
    checkOutput("valid_after_hold", {31'h0, op_valid}, 32'd1);
    base = rd_count;
    ackOp(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("start_with_ack_ignored", rd_count - base, 32'd0);
    checkOutput("ready_stays", {31'h0, ready}, 32'd1);
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    checkOutput("ack_in_idle_ignored", {31'h0, ready}, 32'd1);

    // Reset in WAIT_B; the abandoned read returns 0xDEAD while idle
    lat = 3;
    base = rd_count;
    applyStimulus(16'h0010, 16'h0060, 1'b0, 16'h0, 3'd6);
    repeat (6) @(negedge clk);
    checkOutput("reads_before_reset", rd_count - base, 32'd2);
    reset = 1'b1;
    track = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkResetValues("mid_reset");
    end
    sb.delete();
    rd_q.delete();
    track = 1'b1;

    // Normal fetch after the abandoned one
    lat = 1;
    applyStimulus(16'h0010, 16'h0020, 1'b0, 16'h0, 3'd2);
    waitValid(n);
    checkOutput("lat_after_reset", n, 32'd5);
    ackOp(1'b0);

    repeat (2) @(negedge clk);
    checkOutput("sb_left", sb.size(), 32'd0);
    checkOutput("rd_q_left", rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
